vdp_vram_slot_arbiter: RTL

VDP_VRAM_SLOT_ARBITER -- requirements
Module: vdp_vram_slot_arbiter

---
 rtl/vdp_vram_pkg.sv | 48 ++++
 rtl/vdp_slot_phase.sv | 33 +++
 rtl/vdp_vram_slot_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/vdp_vram_pkg.sv
// Shared VRAM slot timing types, frame geometry and the memory command payload
// used by the slot arbiter and the display fetcher.
package vdp_vram_pkg;

  localparam int unsigned CX_W   = 11;
  localparam int unsigned CY_W   = 10;
  localparam int unsigned ADDR_W = 17;
  localparam int unsigned DATA_W = 32;

  localparam int unsigned FRAME_WIDTH_NTSC  = 856;
  localparam int unsigned FRAME_WIDTH_PAL   = 864;
  localparam int unsigned FRAME_HEIGHT_NTSC = 262;
  localparam int unsigned FRAME_HEIGHT_PAL  = 312;

  // Display prefetch window on the last line where the CPU is locked out
  localparam int unsigned GUARD_CX_LO = 716;
  localparam int unsigned GUARD_CX_HI = 727;

  typedef enum logic [1:0] {
    PH_DL = 2'd0,
    PH_DR = 2'd1,
    PH_AP = 2'd2,
    PH_FS = 2'd3
  } slot_phase_t;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_CPU_CMD  = 2'd1,
    ARB_CPU_WAIT = 2'd2,
    ARB_CPU_ACK  = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rd;
    logic              wr;
  } vram_cmd_t;

  function automatic logic [CX_W-1:0] last_cx(input logic pal);
    return pal ? CX_W'(FRAME_WIDTH_PAL - 1) : CX_W'(FRAME_WIDTH_NTSC - 1);
  endfunction

  function automatic logic [CY_W-1:0] last_cy(input logic pal);
    return pal ? CY_W'(FRAME_HEIGHT_PAL - 1) : CY_W'(FRAME_HEIGHT_NTSC - 1);
  endfunction

endpackage

// File: rtl/vdp_slot_phase.sv
// Free-running 4-phase VRAM slot counter, realigned to DL at the start of every line
// so that the arbiter and the display fetcher agree on slot boundaries.
module vdp_slot_phase
  import vdp_vram_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            pal_mode_i,
  input  logic [CX_W-1:0] cx_i,
  output logic [1:0]      phase_o
);

  slot_phase_t phase_q;
  slot_phase_t phase_d;

  always_comb begin
    phase_d = slot_phase_t'(2'(phase_q + 2'd1));
    if (cx_i == last_cx(pal_mode_i)) begin
      phase_d = PH_DL;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= PH_DL;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/vdp_vram_slot_arbiter.sv
// Shares one VRAM slot per 4-cycle group between the display fetcher and the CPU;
// the owner is chosen on the edge closing AP and the access runs in FS.
module vdp_vram_slot_arbiter
  import vdp_vram_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              super_high_res_i,
  input  logic              pal_mode_i,
  input  logic [CX_W-1:0]   cx_i,
  input  logic [CY_W-1:0]   cy_i,
  input  logic              disp_need_i,
  input  logic [ADDR_W-1:0] disp_addr_i,
  output logic              disp_strobe_o,
  input  logic              cpu_req_i,
  input  logic              cpu_wr_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_ack_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic [ADDR_W-1:0] vram_addr_o,
  output logic              vram_rd_o,
  output logic              vram_wr_o,
  output logic [DATA_W-1:0] vram_wdata_o,
  input  logic [DATA_W-1:0] vram_rdata_i
);

  logic [1:0]  phase_raw;
  slot_phase_t phase;

  vdp_slot_phase u_slot_phase (
    .clk        (clk),
    .reset_n    (reset_n),
    .pal_mode_i (pal_mode_i),
    .cx_i       (cx_i),
    .phase_o    (phase_raw)
  );

  assign phase = slot_phase_t'(phase_raw);

  arb_state_t        state_q, state_d;
  vram_cmd_t         cmd_q, cmd_d;
  logic              cpu_wr_q, cpu_wr_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              disp_pend_q, disp_pend_d;
  logic              disp_strobe_q, disp_strobe_d;

  logic frame_end_guard;
  logic disp_win;
  logic disp_grant;
  logic cpu_grant;

  // Slot ownership decision, evaluated on the edge that closes AP
  always_comb begin
    frame_end_guard = (cy_i == last_cy(pal_mode_i))
                   && (cx_i >= CX_W'(GUARD_CX_LO))
                   && (cx_i <= CX_W'(GUARD_CX_HI));
    disp_win   = super_high_res_i & disp_need_i;
    disp_grant = (phase == PH_AP) & disp_win;
    cpu_grant  = (phase == PH_AP) & ~disp_win & cpu_req_i & ~cpu_ack_q
               & (state_q == ARB_IDLE) & ~frame_end_guard;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:     if (cpu_grant)        state_d = ARB_CPU_CMD;
      ARB_CPU_CMD:  if (phase == PH_FS)   state_d = ARB_CPU_WAIT;
      ARB_CPU_WAIT: if (phase == PH_DR)   state_d = ARB_CPU_ACK;
      ARB_CPU_ACK:  if (phase == PH_AP)   state_d = ARB_IDLE;
      default:                            state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    cmd_d    = cmd_q;
    cmd_d.rd = 1'b0;
    cmd_d.wr = 1'b0;
    if (disp_grant) begin
      cmd_d.addr = disp_addr_i;
      cmd_d.rd   = 1'b1;
    end else if (cpu_grant) begin
      cmd_d.addr = cpu_addr_i;
      cmd_d.rd   = ~cpu_wr_i;
      cmd_d.wr   = cpu_wr_i;
      if (cpu_wr_i) begin
        cmd_d.wdata = cpu_wdata_i;
      end
    end

    cpu_wr_d    = cpu_grant ? cpu_wr_i : cpu_wr_q;
    cpu_ack_d   = (state_q == ARB_CPU_WAIT) && (phase == PH_DR);
    cpu_rdata_d = (cpu_ack_d && !cpu_wr_q) ? vram_rdata_i : cpu_rdata_q;

    // Display ownership is dropped the moment super-high-res goes away
    disp_pend_d = disp_pend_q;
    if (!super_high_res_i) begin
      disp_pend_d = 1'b0;
    end else if (disp_grant) begin
      disp_pend_d = 1'b1;
    end else if (phase == PH_DR) begin
      disp_pend_d = 1'b0;
    end
    disp_strobe_d = disp_pend_q & super_high_res_i & (phase == PH_DR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q         <= '0;
      cpu_wr_q      <= 1'b0;
      cpu_ack_q     <= 1'b0;
      cpu_rdata_q   <= '0;
      disp_pend_q   <= 1'b0;
      disp_strobe_q <= 1'b0;
    end else begin
      cmd_q         <= cmd_d;
      cpu_wr_q      <= cpu_wr_d;
      cpu_ack_q     <= cpu_ack_d;
      cpu_rdata_q   <= cpu_rdata_d;
      disp_pend_q   <= disp_pend_d;
      disp_strobe_q <= disp_strobe_d;
    end
  end

  assign vram_addr_o   = cmd_q.addr;
  assign vram_wdata_o  = cmd_q.wdata;
  assign vram_rd_o     = cmd_q.rd;
  assign vram_wr_o     = cmd_q.wr;
  assign cpu_ack_o     = cpu_ack_q;
  assign cpu_rdata_o   = cpu_rdata_q;
  assign disp_strobe_o = disp_strobe_q;

endmodule
